// File: rtl/uc_pkg.sv
// ============================================================
// Package : uc_pkg
// Brief   : Shared types and opcode/ALU constants for the uc_seq control unit.
// Rev     : 1.0 initial release
// ============================================================
`default_nettype none

package uc_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_HALT = 2'b01,
    ST_STEP = 2'b10
  } uc_state_e;

  localparam logic [5:0] OP_J       = 6'b000000;
  localparam logic [5:0] OP_JZ      = 6'b000001;
  localparam logic [5:0] OP_JNZ     = 6'b000010;
  localparam logic [5:0] OP_HLT     = 6'b000011;
  localparam logic [3:0] OP_NOP_PFX = 4'b0001;
  localparam logic [1:0] OP_LI_PFX  = 2'b01;
  localparam logic       OP_ALU_PFX = 1'b1;

  localparam logic [2:0] ALU_NOP    = 3'b000;

endpackage

`default_nettype wire

// File: rtl/uc_decode.sv
// ============================================================
// Module  : uc_decode
// Brief   : Purely combinational opcode to datapath-control decoder.
// Rev     : 1.0 initial release
// ============================================================
`default_nettype none

module uc_decode
  import uc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       s_inc,
  output logic       s_inm,
  output logic       we,
  output logic       wez,
  output logic [2:0] alu_op,
  output logic       is_hlt
);

  always_comb begin
    s_inc  = 1'b1;
    s_inm  = 1'b0;
    we     = 1'b0;
    wez    = 1'b0;
    alu_op = ALU_NOP;
    is_hlt = 1'b0;
    if (opcode[5] == OP_ALU_PFX) begin
      alu_op = opcode[4:2];
      we     = 1'b1;
      wez    = 1'b1;
    end else if (opcode[5:4] == OP_LI_PFX) begin
      s_inm  = 1'b1;
      we     = 1'b1;
    end else if (opcode[5:2] != OP_NOP_PFX) begin
      // Remaining space is the 0000xx jump/halt group.
      case (opcode)
        OP_J:    s_inc  = 1'b0;
        OP_JZ:   s_inc  = ~zero;
        OP_JNZ:  s_inc  = zero;
        OP_HLT:  is_hlt = 1'b1;
        default: s_inc  = 1'b1;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/uc_seq.sv
// ============================================================
// Module  : uc_seq
// Brief   : Control unit with run/halt/single-step gating of the decoder.
// Config  : define UC_INSTR_COUNT_EN to add the instr_count port/counter.
// Rev     : 1.0 initial release
// ============================================================
`default_nettype none

module uc_seq
  import uc_pkg::*;
#(
  parameter bit          RESET_HALTED = 1'b0,
  parameter int unsigned COUNT_W      = 16
)
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       halt_req,
  input  logic       run_req,
  input  logic       step_req,
  output logic       s_inc,
  output logic       s_inm,
  output logic       we,
  output logic       wez,
  output logic [2:0] ALUOp,
  output logic       pc_en,
  output logic       halted,
  output logic       step_ack
`ifdef UC_INSTR_COUNT_EN
  ,
  output logic [COUNT_W-1:0] instr_count
`endif
);

  localparam uc_state_e c_RESET_STATE = RESET_HALTED ? ST_HALT : ST_RUN;

  uc_state_e  r_state;
  uc_state_e  w_state_nxt;

  logic       w_dec_s_inc;
  logic       w_dec_s_inm;
  logic       w_dec_we;
  logic       w_dec_wez;
  logic [2:0] w_dec_alu_op;
  logic       w_dec_is_hlt;

  uc_decode u_decode (
    .opcode (opcode),
    .zero   (zero),
    .s_inc  (w_dec_s_inc),
    .s_inm  (w_dec_s_inm),
    .we     (w_dec_we),
    .wez    (w_dec_wez),
    .alu_op (w_dec_alu_op),
    .is_hlt (w_dec_is_hlt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_RESET_STATE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (halt_req || w_dec_is_hlt) begin
          w_state_nxt = ST_HALT;
        end
      end
      ST_HALT: begin
        // run_req has priority over a coincident step_req.
        if (run_req) begin
          w_state_nxt = ST_RUN;
        end else if (step_req) begin
          w_state_nxt = ST_STEP;
        end
      end
      ST_STEP: w_state_nxt = ST_HALT;
      default: w_state_nxt = ST_HALT;
    endcase
  end

  always_comb begin
    s_inc    = 1'b1;
    s_inm    = 1'b0;
    we       = 1'b0;
    wez      = 1'b0;
    ALUOp    = ALU_NOP;
    pc_en    = 1'b0;
    halted   = (r_state == ST_HALT);
    step_ack = (r_state == ST_STEP);
    if (r_state == ST_RUN || r_state == ST_STEP) begin
      s_inc  = w_dec_s_inc;
      s_inm  = w_dec_s_inm;
      we     = w_dec_we;
      wez    = w_dec_wez;
      ALUOp  = w_dec_alu_op;
      pc_en  = 1'b1;
    end
  end

`ifdef UC_INSTR_COUNT_EN
  logic [COUNT_W-1:0] r_instr_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_instr_count <= '0;
    end else if (pc_en) begin
      r_instr_count <= r_instr_count + 1'b1;
    end
  end

  assign instr_count = r_instr_count;
`endif

endmodule

`default_nettype wire

// File: doc/uc_seq.md
# uc_seq

Control unit for the 8-bit accumulator-free microcontroller datapath. It decodes the 6-bit opcode into datapath controls (`s_inc`, `s_inm`, `we`, `wez`, `ALUOp`) and gates execution through a run/halt/single-step state machine. It also provides a PC enable, so a debug host can stop, step and resume the core without resetting it. It sits beside the datapath in the core top level, fed by `Opcode` and the registered `zero` flag.

## Interface
- `RESET_HALTED`, 0: state entered on reset (0 = RUN, 1 = HALT)
- `COUNT_W`, 16: retired-instruction counter width (used only when the counter is compiled in)

- `clk` in 1: core clock, rising edge
- `reset` in 1: asynchronous, active-low reset
- `opcode` in 6: current instruction opcode from program memory
- `zero` in 1: registered zero flag from the datapath
- `halt_req` in 1: level; request halt after the current instruction
- `run_req` in 1: one-cycle pulse; resume from HALT
- `step_req` in 1: one-cycle pulse; execute exactly one instruction from HALT
- `s_inc` out 1: 1 = PC+1, 0 = load jump target
- `s_inm` out 1: 1 = immediate operand / immediate destination select
- `we` out 1: register-file write enable
- `wez` out 1: zero-flag write enable
- `ALUOp` out 3: ALU operation
- `pc_en` out 1: PC register update enable
- `halted` out 1: high while in HALT
- `step_ack` out 1: one-cycle pulse when a step has retired
- `instr_count` out COUNT_W: retired instructions (only with `UC_INSTR_COUNT_EN`)

## Operation
- Decode (combinational, gated by the FSM):
  - `1aaaxx`: ALU reg-reg. `ALUOp=aaa`, `we=1`, `wez=1`, `s_inm=0`, `s_inc=1`.
  - `01xxxx`: load immediate. `s_inm=1`, `we=1`, `wez=0`, `ALUOp=000`, `s_inc=1`.
  - `000000`: J. `s_inc=0`.
  - `000001`: JZ. `s_inc=~zero`.
  - `000010`: JNZ. `s_inc=zero`.
  - `000011`: HLT. Retires with `s_inc=1`, then the FSM enters HALT.
  - `0001xx`: NOP. `s_inc=1`.
- All jump, HLT and NOP opcodes drive `we=0`, `wez=0`, `s_inm=0` and `ALUOp=000`.
- States:
  - RUN: decode is active and `pc_en=1`.
  - HALT: `pc_en=0`, `we=0`, `wez=0`, `s_inc=1`, `halted=1`.
  - STEP: one active cycle identical to RUN.
- Transitions:
  - RUN→HALT when `halt_req=1` or the opcode is HLT. The instruction in that cycle still retires.
  - HALT→RUN on `run_req`.
  - HALT→STEP on `step_req`.
  - STEP→HALT unconditionally, with `step_ack=1` in the STEP cycle.
- Priority in HALT: `run_req` wins over `step_req`. `halt_req` is ignored in HALT and STEP.
- An HLT executed in STEP behaves like any other instruction: the FSM returns to HALT and `step_ack` still pulses.

## Timing
- Reset values: state = RUN (or HALT if `RESET_HALTED=1`), `step_ack=0`, `instr_count=0`.
  - Reset to RUN: `halted=0`, `pc_en=1`.
  - Reset to HALT: `halted=1`, `pc_en=0`.
- Reset asserted mid-STEP or mid-run aborts the state immediately, without waiting for a clock edge.
- Control outputs are combinational from `opcode`, `zero` and the state, and are valid in the same cycle as the instruction. Instruction latency is 1 cycle.
- `halt_req` sampled high at edge N: the instruction in cycle N-1 retires, and `halted=1` from edge N onward.
- `step_req` sampled at edge N: STEP occupies cycle N..N+1, `step_ack` is high in that cycle, and `halted` is back at 1 after edge N+1.
- `run_req` or `step_req` while in RUN is ignored.

## Configuration
- `UC_INSTR_COUNT_EN` defined:
  - `instr_count` increments by 1 on every edge where `pc_en=1`.
  - It wraps from 2^COUNT_W−1 to 0.
  - It is cleared by reset.
- `UC_INSTR_COUNT_EN` undefined: the port and the counter are absent.

## Structure
- Package `uc_pkg` holds:
  - the state enum (RUN, HALT, STEP);
  - opcode class constants (`OP_J`, `OP_JZ`, `OP_JNZ`, `OP_HLT`, `OP_LI` prefix, `OP_ALU` prefix);
  - ALU op constants.
- Sub-module `uc_decode`: purely combinational opcode→control decoder. `uc_seq` instantiates it and masks its outputs with the state.

## Test plan
- After reset release, run ALU `101000`: `we=1`, `wez=1`, `ALUOp=010`, `pc_en=1`, `s_inc=1`.
- JZ `000001`:
  - with `zero=1`: `s_inc=0`;
  - with `zero=0`: `s_inc=1`;
  - JNZ gives the inverse result.
- HLT `000011` in RUN: it retires with `pc_en=1`. Next cycle `halted=1`, `pc_en=0`, `we=0`, `wez=0`, held for 10 cycles.
- In HALT, pulse `step_req` with opcode `010101`:
  - exactly one cycle of `pc_en=1`, `we=1`, `s_inm=1` and `step_ack=1`;
  - then `halted=1`;
  - `instr_count` increments by exactly 1.
- In HALT, assert `run_req` and `step_req` in the same cycle: FSM goes to RUN and `step_ack` stays 0.
- Assert `reset` low during the STEP cycle: outputs take reset values immediately. With `UC_INSTR_COUNT_EN`, `instr_count=0`. A wrap test from 16'hFFFF goes to 0.
